// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and result signal bundle for alu_cmd_issuer.
// ALU_ERR_FLAG_EN adds the res_err result flag.
interface alu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_operation;
    logic [8:0] alu_z;
    logic       res_valid;
    logic       res_ready;
    logic [8:0] res_z;
    logic [3:0] res_op;
`ifdef ALU_ERR_FLAG_EN
    logic       res_err;
`endif

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_z, res_ready,
        output cmd_ready, alu_a, alu_b, alu_operation, res_valid, res_z,
`ifdef ALU_ERR_FLAG_EN
        output res_err,
`endif
        output res_op
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_z, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_operation, res_valid, res_z,
`ifdef ALU_ERR_FLAG_EN
        input  res_err,
`endif
        input  res_op
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands in a FIFO, issues them one at a time and returns registered results.
// Optional macro ALU_ERR_FLAG_EN adds the res_err result flag.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_issuer_if.master bus,
    output logic             busy_o,
    output logic [ADDR_W:0]  fifo_count_o
);
    localparam int unsigned     CntW      = ADDR_W + 1;
    localparam logic [ADDR_W:0] FullCount = CntW'(DEPTH);
    localparam logic [3:0]      OpNone    = 4'b1111;

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e            state_q, state_d;
    logic [19:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]        alu_op_q, alu_op_d, res_op_q, res_op_d;
    logic [8:0]        res_z_q, res_z_d;
    logic              res_valid_q, res_valid_d;
    logic              push, pop, empty;
    logic [19:0]       head;
`ifdef ALU_ERR_FLAG_EN
    logic              res_err_q, res_err_d;
`endif

    assign empty         = (count_q == '0);
    assign bus.cmd_ready = (count_q != FullCount);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head          = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_z_d     = res_z_q;
        res_op_d    = res_op_q;
`ifdef ALU_ERR_FLAG_EN
        res_err_d   = res_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop                          = 1'b1;
                    {alu_op_d, alu_a_d, alu_b_d} = head;
                    state_d                      = StIssue;
                end
            end
            StIssue: begin
                res_z_d     = bus.alu_z;
                res_op_d    = alu_op_q;
                res_valid_d = 1'b1;
`ifdef ALU_ERR_FLAG_EN
                res_err_d   = (alu_op_q >= 4'b1010) || ((alu_op_q == 4'b0010) && (alu_b_q == 8'd0));
`endif
                state_d     = StHold;
            end
            StHold: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (!empty) begin
                        pop                          = 1'b1;
                        {alu_op_d, alu_a_d, alu_b_d} = head;
                        state_d                      = StIssue;
                    end else begin
                        alu_op_d  = OpNone;
`ifdef ALU_ERR_FLAG_EN
                        res_err_d = 1'b0;
`endif
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= 8'd0;
            alu_b_q     <= 8'd0;
            alu_op_q    <= OpNone;
            res_valid_q <= 1'b0;
            res_z_q     <= 9'd0;
            res_op_q    <= 4'd0;
`ifdef ALU_ERR_FLAG_EN
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_z_q     <= res_z_d;
            res_op_q    <= res_op_d;
`ifdef ALU_ERR_FLAG_EN
            res_err_q   <= res_err_d;
`endif
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
    end

    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.alu_operation = alu_op_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_z         = res_z_q;
    assign bus.res_op        = res_op_q;
`ifdef ALU_ERR_FLAG_EN
    assign bus.res_err       = res_err_q;
`endif
    assign busy_o            = (state_q != StIdle) || !empty;
    assign fifo_count_o      = count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU and a result scoreboard.
// Define ALU_ERR_FLAG_EN to also check res_err.
module tb_alu_cmd_issuer;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;

    typedef struct {
        logic [8:0] z;
        logic [3:0] op;
        logic       err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            busy;
    logic [ADDR_W:0] fifo_count;
    logic [8:0]      alu_z_model;
    exp_t            exp_q[$];
    int              errors = 0;
    int              checks = 0;

    alu_cmd_issuer_if bus ();

    alu_cmd_issuer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy_o       (busy),
        .fifo_count_o (fifo_count)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit ALU: 0 add, 1 sub, 2 div, 3 mul, 4 and, 5 or, 6 xor, 7 not a, 8 shl, 9 shr.
    always_comb begin
        alu_z_model = 9'd0;
        case (bus.alu_operation)
            4'd0: alu_z_model = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'd1: alu_z_model = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            4'd2: alu_z_model = (bus.alu_b == 8'd0) ? 9'd0 : {1'b0, bus.alu_a / bus.alu_b};
            4'd3: alu_z_model = {1'b0, bus.alu_a} * {1'b0, bus.alu_b};
            4'd4: alu_z_model = {1'b0, bus.alu_a & bus.alu_b};
            4'd5: alu_z_model = {1'b0, bus.alu_a | bus.alu_b};
            4'd6: alu_z_model = {1'b0, bus.alu_a ^ bus.alu_b};
            4'd7: alu_z_model = {1'b0, ~bus.alu_a};
            4'd8: alu_z_model = {bus.alu_a, 1'b0};
            4'd9: alu_z_model = {2'b00, bus.alu_a[7:1]};
            default: alu_z_model = 9'd0;
        endcase
    end
    assign bus.alu_z = alu_z_model;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = 8'd0;
        bus.cmd_b = 8'd0;
        bus.cmd_op = 4'd0;
        bus.res_ready = 1'b0;
        #2;
        checks++; if (fifo_count !== 3'd0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_fifo count=%0d ready=%b busy=%b exp 0/1/0", fifo_count, bus.cmd_ready, busy); end
        checks++; if (bus.alu_a !== 8'd0 || bus.alu_b !== 8'd0 || bus.alu_operation !== 4'b1111) begin
            errors++; $display("FAIL reset_alu a=%h b=%h op=%b exp 00/00/1111", bus.alu_a, bus.alu_b, bus.alu_operation); end
        checks++; if (bus.res_valid !== 1'b0 || bus.res_z !== 9'd0 || bus.res_op !== 4'd0) begin
            errors++; $display("FAIL reset_res valid=%b z=%h op=%b exp 0/000/0000", bus.res_valid, bus.res_z, bus.res_op); end
`ifdef ALU_ERR_FLAG_EN
        checks++; if (bus.res_err !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b exp=0", bus.res_err); end
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        exp_t e;
        bus.res_ready = 1'b1;
        bus.cmd_a = 8'd200; bus.cmd_b = 8'd100; bus.cmd_op = 4'b0000; bus.cmd_valid = 1'b1;
        checks++; if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready got=%b exp=1", bus.cmd_ready); end
        exp_q.push_back('{9'd300, 4'b0000, 1'b0});
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1 || bus.alu_operation !== 4'b1111) begin
            errors++; $display("FAIL single_accept count=%0d op=%b exp 1/1111", fifo_count, bus.alu_operation); end
        tick();
        checks++; if (bus.alu_operation !== 4'b0000 || bus.alu_a !== 8'd200 || bus.alu_b !== 8'd100 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL single_issue op=%b a=%0d b=%0d valid=%b exp 0000/200/100/0",
                               bus.alu_operation, bus.alu_a, bus.alu_b, bus.res_valid); end
        tick();
        checks++; if (bus.res_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid got=%b exp=1", bus.res_valid); end
        else begin
            e = exp_q.pop_front();
            checks++; if (bus.res_z !== e.z || bus.res_op !== e.op) begin
                errors++; $display("FAIL single_result z=%0d op=%b exp %0d/%b", bus.res_z, bus.res_op, e.z, e.op); end
        end
        tick();
        checks++; if (bus.res_valid !== 1'b0 || bus.alu_operation !== 4'b1111 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle valid=%b op=%b busy=%b exp 0/1111/0", bus.res_valid, bus.alu_operation, busy); end
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic [8:0] zs [5];
        zs[0] = 9'h000; zs[1] = 9'h0FF; zs[2] = 9'h0FF; zs[3] = 9'h00F; zs[4] = 9'h1E0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_a = 8'hF0; bus.cmd_b = 8'h0F; bus.cmd_op = 4'(4 + i); bus.cmd_valid = 1'b1;
            checks++; if (bus.cmd_ready !== 1'b1) begin
                errors++; $display("FAIL stall_accept%0d ready=%b exp=1", i, bus.cmd_ready); end
            exp_q.push_back('{zs[i], 4'(4 + i), 1'b0});
            tick();
        end
        bus.cmd_a = 8'h11; bus.cmd_b = 8'h22; bus.cmd_op = 4'd0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin
                errors++; $display("FAIL stall_full ready=%b count=%0d exp 0/4", bus.cmd_ready, fifo_count); end
            checks++; if (bus.res_valid !== 1'b1 || bus.res_z !== 9'h000 || bus.res_op !== 4'b0100) begin
                errors++; $display("FAIL stall_hold valid=%b z=%h op=%b exp 1/000/0100", bus.res_valid, bus.res_z, bus.res_op); end
            tick();
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_stream();
        exp_t e;
        int   last = -1;
        bus.res_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                e = exp_q.pop_front();
                checks++; if (bus.res_z !== e.z || bus.res_op !== e.op) begin
                    errors++; $display("FAIL stream_result z=%h op=%b exp %h/%b", bus.res_z, bus.res_op, e.z, e.op); end
`ifdef ALU_ERR_FLAG_EN
                checks++; if (bus.res_err !== e.err) begin
                    errors++; $display("FAIL stream_err got=%b exp=%b", bus.res_err, e.err); end
`endif
                if (last >= 0) begin
                    checks++; if (cyc - last != 2) begin
                        errors++; $display("FAIL stream_spacing got=%0d exp=2", cyc - last); end
                end
                last = cyc;
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL stream_timeout pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
        checks++; if (busy !== 1'b0 || bus.alu_operation !== 4'b1111) begin
            errors++; $display("FAIL stream_idle busy=%b op=%b exp 0/1111", busy, bus.alu_operation); end
    endtask

    task automatic test_errors();
        exp_t e;
        logic [7:0] as [3];
        logic [7:0] bs [3];
        logic [3:0] ops [3];
        logic [8:0] zs [3];
        logic       errs [3];
        as[0] = 8'd50; bs[0] = 8'd0; ops[0] = 4'b0010; zs[0] = 9'd0; errs[0] = 1'b1;
        as[1] = 8'd7;  bs[1] = 8'd9; ops[1] = 4'b1100; zs[1] = 9'd0; errs[1] = 1'b1;
        as[2] = 8'd5;  bs[2] = 8'd3; ops[2] = 4'b0001; zs[2] = 9'd2; errs[2] = 1'b0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_a = as[i]; bus.cmd_b = bs[i]; bus.cmd_op = ops[i]; bus.cmd_valid = 1'b1;
            exp_q.push_back('{zs[i], ops[i], errs[i]});
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                e = exp_q.pop_front();
                checks++; if (bus.res_z !== e.z || bus.res_op !== e.op) begin
                    errors++; $display("FAIL err_result z=%h op=%b exp %h/%b", bus.res_z, bus.res_op, e.z, e.op); end
`ifdef ALU_ERR_FLAG_EN
                checks++; if (bus.res_err !== e.err) begin
                    errors++; $display("FAIL err_flag op=%b got=%b exp=%b", e.op, bus.res_err, e.err); end
`endif
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL err_timeout pending=%0d exp=0", exp_q.size()); exp_q.delete(); end
`ifdef ALU_ERR_FLAG_EN
        checks++; if (bus.res_err !== 1'b0) begin
            errors++; $display("FAIL err_idle_clear got=%b exp=0", bus.res_err); end
`endif
    endtask

    task automatic test_fifo_edges();
        exp_t e;
        bus.res_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.cmd_a = 8'(10 * k); bus.cmd_b = 8'(k); bus.cmd_op = 4'd0; bus.cmd_valid = 1'b1;
            exp_q.push_back('{9'(11 * k), 4'd0, 1'b0});
            tick();
        end
        checks++; if (fifo_count !== 3'd2 || bus.res_valid !== 1'b1) begin
            errors++; $display("FAIL edge_setup count=%0d valid=%b exp 2/1", fifo_count, bus.res_valid); end
        bus.cmd_a = 8'd40; bus.cmd_b = 8'd4;
        exp_q.push_back('{9'd44, 4'd0, 1'b0});
        bus.res_ready = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.res_z !== e.z) begin
            errors++; $display("FAIL edge_res1 z=%0d exp=%0d", bus.res_z, e.z); end
        tick();
        checks++; if (fifo_count !== 3'd2) begin
            errors++; $display("FAIL edge_pushpop count=%0d exp=2", fifo_count); end
        bus.res_ready = 1'b0;
        for (int k = 5; k <= 6; k++) begin
            bus.cmd_a = 8'(10 * k); bus.cmd_b = 8'(k);
            exp_q.push_back('{9'(11 * k), 4'd0, 1'b0});
            tick();
        end
        checks++; if (fifo_count !== 3'(DEPTH) || bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL edge_full count=%0d ready=%b exp %0d/0", fifo_count, bus.cmd_ready, DEPTH); end
        bus.cmd_a = 8'd70; bus.cmd_b = 8'd7;
        bus.res_ready = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_z !== e.z) begin
            errors++; $display("FAIL edge_res2 valid=%b z=%0d exp 1/%0d", bus.res_valid, bus.res_z, e.z); end
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (fifo_count !== 3'(DEPTH - 1)) begin
            errors++; $display("FAIL edge_full_refuse count=%0d exp=%0d", fifo_count, DEPTH - 1); end
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                e = exp_q.pop_front();
                checks++; if (bus.res_z !== e.z || bus.res_op !== e.op) begin
                    errors++; $display("FAIL edge_drain z=%0d op=%b exp %0d/%b", bus.res_z, bus.res_op, e.z, e.op); end
            end
            tick();
        end
        checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL edge_end pending=%0d busy=%b exp 0/0", exp_q.size(), busy); exp_q.delete(); end
    endtask

    task automatic test_async_reset();
        bus.res_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.cmd_a = 8'(k); bus.cmd_b = 8'(k); bus.cmd_op = 4'd0; bus.cmd_valid = 1'b1;
            tick();
        end
        bus.cmd_valid = 1'b0;
        checks++; if (fifo_count !== 3'd3 || bus.res_valid !== 1'b1) begin
            errors++; $display("FAIL arst_setup count=%0d valid=%b exp 3/1", fifo_count, bus.res_valid); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.res_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL arst_immediate valid=%b count=%0d busy=%b exp 0/0/0", bus.res_valid, fifo_count, busy); end
        checks++; if (bus.alu_operation !== 4'b1111 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL arst_alu op=%b ready=%b exp 1111/1", bus.alu_operation, bus.cmd_ready); end
        exp_q.delete();
        tick();
        tick();
        #2;
        rst = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.res_valid !== 1'b0 || fifo_count !== 3'd0) begin
                errors++; $display("FAIL arst_stale cyc=%0d valid=%b count=%0d exp 0/0", i, bus.res_valid, fifo_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_stream();
        test_errors();
        test_fifo_edges();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
